mlp_event_scheduler: RTL and testbench
======================================

Name: mlp_event_scheduler

Overview:
Front-end controller for the MLP activation builder. Buffers incoming CAVIAR events with timestamps in a small FIFO and issues them one at a time to the activation builder as a one-cycle valid pulse. It then waits for the builder's done pulse. While the builder runs, it also owns the timestamp-memory port, arbitrating between the builder's read/write traffic and a full-array clear sweep engine.

Parameters:
CAVIAR_X_Y_BITS, 9, x/y coordinate width; event word is 2*CAVIAR_X_Y_BITS+1 bits, {x, y, polarity}.
TIMESTAMP_BITS, 16, timestamp width.
WORD_SIZE, 18, memory data width.
DVS_WIDTH, 346, x extent swept by clear.
DVS_HEIGHT, 260, y extent swept by clear.
FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2.
TIMEOUT_CYCLES, 64, maximum BUSY cycles allowed before abort.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
evt_in  in  2*CAVIAR_X_Y_BITS+1  incoming CAVIAR event.
evt_ts  in  TIMESTAMP_BITS  event timestamp.
evt_vld  in  1  event valid.
evt_rdy  out  1  event accept; equals !fifo_full.
clear_req  in  1  one-cycle request to zero the whole memory.
clear_busy  out  1  high while a clear is pending or sweeping.
act_cavier  out  2*CAVIAR_X_Y_BITS+1  event to the builder.
act_ts  out  TIMESTAMP_BITS  timestamp to the builder.
act_vld  out  1  one-cycle issue pulse; drives both the builder's event valid and timestamp valid.
act_done  in  1  builder finished (store cycle).
act_rw, act_cen  in  1 each  builder memory controls.
act_addr_x, act_addr_y  in  CAVIAR_X_Y_BITS each  builder address.
act_wdata  in  WORD_SIZE  builder write data.
mem_rw, mem_cen  out  1 each  to memory; rw=1 means write, cen=1 means access enabled.
mem_addr_x, mem_addr_y  out  CAVIAR_X_Y_BITS each  memory address.
mem_wdata  out  WORD_SIZE  memory write data.
evt_drop  out  1  sticky; set when evt_vld && !evt_rdy.
timeout_err  out  1  sticky; set on a BUSY timeout.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; FIFO is emptied; all counters go to 0.
  - All outputs are 0 except evt_rdy=1.
  - A reset mid-sweep or mid-BUSY aborts the operation immediately. Any pending clear is discarded.
- FIFO:
  - Push when evt_vld && evt_rdy.
  - Pop on the ISSUE cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, evt_rdy=0 and the offered event is not stored; evt_drop is set if evt_vld=1.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_pending:
  - Set by clear_req in any state; cleared on entry to CLEAR.
  - clear_busy = clear_pending || state==CLEAR.
- FSM states: IDLE, ISSUE, BUSY, CLEAR.
  - IDLE: go to CLEAR if clear_pending (clear has priority over events); else go to ISSUE if FIFO is non-empty; else stay.
  - ISSUE (1 cycle, registered outputs): act_vld=1, act_cavier/act_ts = FIFO head, pop, then go to BUSY. act_cavier/act_ts hold their value until the next ISSUE.
  - BUSY: memory mux passes the builder through. A timeout counter increments each cycle.
    - act_done=1: go to IDLE. The done cycle itself is passed through, so the builder's store write reaches memory.
    - Counter reaches TIMEOUT_CYCLES-1 without done: set timeout_err, go to IDLE.
  - CLEAR: sweep y outer 0..DVS_HEIGHT-1, x inner 0..DVS_WIDTH-1, one write per cycle with mem_rw=1, mem_cen=1, mem_wdata=0.
    - Exactly DVS_WIDTH*DVS_HEIGHT write cycles.
    - After the write to (DVS_WIDTH-1, DVS_HEIGHT-1), go to IDLE and reset the counters.
    - A clear_req arriving during CLEAR re-arms clear_pending, which forces one more full sweep.
- Memory mux (combinational from state and inputs):
  - BUSY: mem_* = act_*.
  - CLEAR: sweep counters drive the address; write data is 0.
  - IDLE/ISSUE: mem_cen=0, mem_rw=0, address=0, mem_wdata=0.
- act_* inputs are ignored outside BUSY. An act_done outside BUSY is ignored.
- Events continue to be accepted into the FIFO during BUSY and CLEAR.
- Issue-to-issue minimum spacing: 1 ISSUE cycle + BUSY duration + 1 IDLE cycle.

Test Plan:
- Single event: push evt_in=0x1_2345, evt_ts=0x00C8 into an idle block. act_vld pulses exactly 1 cycle, 2 cycles after the push, carrying the same values. Builder model asserts act_done 30 cycles later with act_rw=1. mem_rw=1 and mem_addr mirror act_* on that cycle. FSM returns to IDLE.
- Backpressure: with act_done withheld for 60 cycles, push 10 back-to-back events at FIFO_DEPTH=8. The first is issued; evt_rdy drops once the FIFO holds 8 pending events; the 10th is refused and evt_drop=1. Afterwards the 8 buffered events are issued in order.
- Clear priority: with DVS_WIDTH=4, DVS_HEIGHT=3, pulse clear_req during BUSY while 2 events are queued. After act_done the FSM enters CLEAR and issues 12 zero-writes in order (0,0),(1,0),...,(3,2). Only then are the 2 queued events issued. clear_busy is high from the cycle after clear_req to the last write.
- Timeout: issue an event and never assert act_done. After TIMEOUT_CYCLES BUSY cycles, timeout_err=1 and stays set; the next queued event is issued normally.
- Simultaneous push/pop: push on the ISSUE cycle with the FIFO holding 1 entry. The count stays 1 and the new event is issued next.
- Reset mid-CLEAR: assert rst at sweep write 5. All outputs go to their reset values immediately and no further writes occur. After release, the FSM is in IDLE with clear_busy=0.

Source files
------------

// File: rtl/mlp_event_scheduler.sv
// Event front-end for the MLP activation builder: buffers timestamped CAVIAR events,
// issues them one at a time, and owns the timestamp memory port (builder pass-through or clear sweep).
module mlp_event_scheduler #(
    parameter int CAVIAR_X_Y_BITS = 9,
    parameter int TIMESTAMP_BITS  = 16,
    parameter int WORD_SIZE       = 18,
    parameter int DVS_WIDTH       = 346,
    parameter int DVS_HEIGHT      = 260,
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*CAVIAR_X_Y_BITS:0]   evt_in,
    input  logic [TIMESTAMP_BITS-1:0]    evt_ts,
    input  logic                         evt_vld,
    output logic                         evt_rdy,
    input  logic                         clear_req,
    output logic                         clear_busy,
    output logic [2*CAVIAR_X_Y_BITS:0]   act_cavier,
    output logic [TIMESTAMP_BITS-1:0]    act_ts,
    output logic                         act_vld,
    input  logic                         act_done,
    input  logic                         act_rw,
    input  logic                         act_cen,
    input  logic [CAVIAR_X_Y_BITS-1:0]   act_addr_x,
    input  logic [CAVIAR_X_Y_BITS-1:0]   act_addr_y,
    input  logic [WORD_SIZE-1:0]         act_wdata,
    output logic                         mem_rw,
    output logic                         mem_cen,
    output logic [CAVIAR_X_Y_BITS-1:0]   mem_addr_x,
    output logic [CAVIAR_X_Y_BITS-1:0]   mem_addr_y,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    output logic                         evt_drop,
    output logic                         timeout_err
);
    localparam int EW = 2*CAVIAR_X_Y_BITS+1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CAVIAR_X_Y_BITS-1:0] X_LAST   = CAVIAR_X_Y_BITS'(DVS_WIDTH-1);
    localparam logic [CAVIAR_X_Y_BITS-1:0] Y_LAST   = CAVIAR_X_Y_BITS'(DVS_HEIGHT-1);
    localparam logic [TW-1:0]              TO_LAST  = TW'(TIMEOUT_CYCLES-1);
    localparam logic [PW:0]                FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, CLEAR} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]             fifo_evt [FIFO_DEPTH];
    logic [TIMESTAMP_BITS-1:0] fifo_ts  [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [PW:0]               count;
    logic                      push, pop, clear_pending, sweep_last, timeout_hit;
    logic [CAVIAR_X_Y_BITS-1:0] sweep_x, sweep_y;
    logic [TW-1:0]             busy_cnt;

    assign evt_rdy     = (count != FULL_CNT);
    assign push        = evt_vld && evt_rdy;
    assign pop         = (state_q == ISSUE);
    assign sweep_last  = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
    assign timeout_hit = (busy_cnt == TO_LAST) && !act_done;
    assign clear_busy  = clear_pending || (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A pending clear wins over queued events.
                if (clear_pending)      state_d = CLEAR;
                else if (count != '0)   state_d = ISSUE;
            end
            ISSUE:   state_d = BUSY;
            BUSY:    if (act_done || timeout_hit) state_d = IDLE;
            CLEAR:   if (sweep_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rw     = 1'b0;
        mem_cen    = 1'b0;
        mem_addr_x = '0;
        mem_addr_y = '0;
        mem_wdata  = '0;
        case (state_q)
            BUSY: begin
                mem_rw     = act_rw;
                mem_cen    = act_cen;
                mem_addr_x = act_addr_x;
                mem_addr_y = act_addr_y;
                mem_wdata  = act_wdata;
            end
            CLEAR: begin
                mem_rw     = 1'b1;
                mem_cen    = 1'b1;
                mem_addr_x = sweep_x;
                mem_addr_y = sweep_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_evt[wr_ptr] <= evt_in;
            fifo_ts[wr_ptr]  <= evt_ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            clear_pending <= 1'b0;
            act_vld       <= 1'b0;
            act_cavier    <= '0;
            act_ts        <= '0;
            evt_drop      <= 1'b0;
            timeout_err   <= 1'b0;
            sweep_x       <= '0;
            sweep_y       <= '0;
            busy_cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A request landing on the entry cycle re-arms for another sweep.
            if (clear_req)
                clear_pending <= 1'b1;
            else if (state_q == IDLE && state_d == CLEAR)
                clear_pending <= 1'b0;
            act_vld <= (state_d == ISSUE);
            if (state_d == ISSUE) begin
                act_cavier <= fifo_evt[rd_ptr];
                act_ts     <= fifo_ts[rd_ptr];
            end
            if (evt_vld && !evt_rdy) evt_drop <= 1'b1;
            busy_cnt <= (state_q == BUSY) ? busy_cnt + 1'b1 : '0;
            if (state_q == BUSY && timeout_hit) timeout_err <= 1'b1;
            if (state_q == CLEAR) begin
                if (sweep_x == X_LAST) begin
                    sweep_x <= '0;
                    sweep_y <= sweep_last ? '0 : sweep_y + 1'b1;
                end else begin
                    sweep_x <= sweep_x + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mlp_event_scheduler.sv
// Bench for mlp_event_scheduler: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mlp_event_scheduler;
    localparam int XYB = 9, TSB = 16, WS = 18, W = 4, H = 3, FD = 8, TO = 64;
    localparam int EW = 2*XYB+1;
    localparam int MI = 0, MS = 1, MB = 2, MC = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic [EW-1:0] evt_in = '0, act_cavier;
    logic [TSB-1:0] evt_ts = '0, act_ts;
    logic evt_vld = 0, evt_rdy, clear_req = 0, clear_busy, act_vld;
    logic act_done = 0, act_rw = 0, act_cen = 0;
    logic [XYB-1:0] act_addr_x = 9'h155, act_addr_y = 9'h0AA, mem_addr_x, mem_addr_y;
    logic [WS-1:0] act_wdata = 18'h3FFFF, mem_wdata;
    logic mem_rw, mem_cen, evt_drop, timeout_err;

    mlp_event_scheduler #(
        .CAVIAR_X_Y_BITS(XYB), .TIMESTAMP_BITS(TSB), .WORD_SIZE(WS), .DVS_WIDTH(W),
        .DVS_HEIGHT(H), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_ts(evt_ts), .evt_vld(evt_vld),
        .evt_rdy(evt_rdy), .clear_req(clear_req), .clear_busy(clear_busy),
        .act_cavier(act_cavier), .act_ts(act_ts), .act_vld(act_vld), .act_done(act_done),
        .act_rw(act_rw), .act_cen(act_cen), .act_addr_x(act_addr_x), .act_addr_y(act_addr_y),
        .act_wdata(act_wdata), .mem_rw(mem_rw), .mem_cen(mem_cen), .mem_addr_x(mem_addr_x),
        .mem_addr_y(mem_addr_y), .mem_wdata(mem_wdata), .evt_drop(evt_drop),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: pending events as a queue, clear progress as a linear write index.
    logic [EW+TSB-1:0] mq[$];
    int m_mode, m_el, m_k;
    bit m_pend, m_drop, m_terr;
    logic [EW-1:0] m_aevt;
    logic [TSB-1:0] m_ats;

    task automatic m_reset();
        mq.delete();
        m_mode = MI; m_el = 0; m_k = 0;
        m_pend = 0; m_drop = 0; m_terr = 0;
        m_aevt = '0; m_ats = '0;
    endtask

    task automatic m_step();
        bit room, enter_clr;
        room = mq.size() < FD;
        enter_clr = 0;
        if (evt_vld && !room) m_drop = 1;
        case (m_mode)
            MI: if (m_pend) begin m_mode = MC; m_k = 0; enter_clr = 1; end
                else if (mq.size() > 0) begin m_mode = MS; {m_aevt, m_ats} = mq[0]; end
            MS: begin void'(mq.pop_front()); m_mode = MB; m_el = 0; end
            MB: if (act_done) m_mode = MI;
                else if (m_el == TO-1) begin m_terr = 1; m_mode = MI; end
                else m_el++;
            default: if (m_k == W*H-1) m_mode = MI; else m_k++;
        endcase
        if (clear_req) m_pend = 1; else if (enter_clr) m_pend = 0;
        if (evt_vld && room) mq.push_back({evt_in, evt_ts});
    endtask

    initial forever begin
        logic e_rw, e_cen;
        logic [63:0] e_x, e_y, e_d;
        @(negedge clk);
        if (rst) m_reset();
        e_rw = 0; e_cen = 0; e_x = 0; e_y = 0; e_d = 0;
        if (m_mode == MB) begin
            e_rw = act_rw; e_cen = act_cen; e_x = 64'(act_addr_x); e_y = 64'(act_addr_y);
            e_d = 64'(act_wdata);
        end else if (m_mode == MC) begin
            e_rw = 1; e_cen = 1; e_x = 64'(m_k % W); e_y = 64'(m_k / W);
        end
        chk("m_evt_rdy", evt_rdy, mq.size() < FD);
        chk("m_act_vld", act_vld, m_mode == MS);
        chk("m_act_cavier", act_cavier, m_aevt);
        chk("m_act_ts", act_ts, m_ats);
        chk("m_clear_busy", clear_busy, m_pend || m_mode == MC);
        chk("m_mem_rw", mem_rw, e_rw);
        chk("m_mem_cen", mem_cen, e_cen);
        chk("m_mem_addr_x", mem_addr_x, e_x);
        chk("m_mem_addr_y", mem_addr_y, e_y);
        chk("m_mem_wdata", mem_wdata, e_d);
        chk("m_evt_drop", evt_drop, m_drop);
        chk("m_timeout_err", timeout_err, m_terr);
        if (!rst) m_step();
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_issue(input logic [EW-1:0] e, input logic [TSB-1:0] ts);
        bit ok = 0;
        for (int i = 0; i <= 20; i++) begin
            if (act_vld) begin ok = 1; break; end
            tick();
        end
        chk("issue_seen", ok, 1);
        chk("issue_evt", act_cavier, e);
        chk("issue_ts", act_ts, ts);
    endtask

    // Builder answers with a store on BUSY cycle n-1; leaves the bench in the following IDLE cycle.
    task automatic finish_busy(input int n);
        repeat (n) tick();
        act_done = 1; act_rw = 1; act_cen = 1;
        tick();
        act_done = 0; act_rw = 0; act_cen = 0;
    endtask

    task automatic push1(input logic [EW-1:0] e, input logic [TSB-1:0] ts);
        evt_vld = 1; evt_in = e; evt_ts = ts;
        tick();
        evt_vld = 0;
    endtask

    int xs[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int ys[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_rdy", evt_rdy, 1);
        chk("rst_act_vld", act_vld, 0);
        chk("rst_mem_addr_x", mem_addr_x, 0);
        chk("rst_clear_busy", clear_busy, 0);
        rst = 0;
        tick();
        act_done = 1;               // ignored outside BUSY
        tick();
        act_done = 0;
        tick();

        // Single event
        push1(19'h12345, 16'h00C8);
        chk("single_vld_early", act_vld, 0);
        tick();
        chk("single_vld", act_vld, 1);
        chk("single_evt", act_cavier, 19'h12345);
        chk("single_ts", act_ts, 16'h00C8);
        tick();
        chk("single_pulse_len", act_vld, 0);
        repeat (29) tick();
        act_done = 1; act_rw = 1; act_cen = 1;
        act_addr_x = 9'h045; act_addr_y = 9'h123; act_wdata = 18'h2ABCD;
        #1;
        chk("done_mem_rw", mem_rw, 1);
        chk("done_mem_cen", mem_cen, 1);
        chk("done_mem_x", mem_addr_x, 9'h045);
        chk("done_mem_y", mem_addr_y, 9'h123);
        chk("done_mem_wdata", mem_wdata, 18'h2ABCD);
        tick();
        act_done = 0;
        #1;
        chk("idle_mem_cen", mem_cen, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        act_rw = 0; act_cen = 0;

        // Push on the ISSUE cycle with one entry held
        push1(19'h00A0A, 16'h1111);
        tick();
        chk("pp_issue_a", act_cavier, 19'h00A0A);
        evt_vld = 1; evt_in = 19'h54321; evt_ts = 16'h2222;
        tick();
        evt_vld = 0; act_done = 1; act_cen = 1;
        tick();
        act_done = 0; act_cen = 0;
        tick();
        chk("pp_issue_b_vld", act_vld, 1);
        chk("pp_issue_b_evt", act_cavier, 19'h54321);
        chk("pp_issue_b_ts", act_ts, 16'h2222);
        finish_busy(3);

        // Backpressure: 10 back-to-back events against an 8-deep FIFO
        for (int i = 0; i < 10; i++) begin
            evt_vld = 1; evt_in = 19'(32'h100 + i); evt_ts = 16'(32'h0500 + i);
            if (i == 2) chk("bp_first_issue", act_cavier, 19'h00100);
            if (i == 8) chk("bp_rdy_7", evt_rdy, 1);
            if (i == 9) begin
                chk("bp_rdy_full", evt_rdy, 0);
                chk("bp_drop_before", evt_drop, 0);
            end
            tick();
        end
        evt_vld = 0;
        chk("bp_drop", evt_drop, 1);
        repeat (52) tick();
        act_done = 1;
        tick();
        act_done = 0;
        for (int i = 1; i < 9; i++) begin
            check_issue(19'(32'h100 + i), 16'(32'h0500 + i));
            finish_busy(2);
        end
        repeat (3) begin
            tick();
            chk("bp_no_tenth", act_vld, 0);
        end

        // Clear priority over queued events
        push1(19'h00F00, 16'h0F00);
        check_issue(19'h00F00, 16'h0F00);
        tick();
        evt_vld = 1; evt_in = 19'h00F01; evt_ts = 16'h0F01;
        tick();
        evt_in = 19'h00F02; evt_ts = 16'h0F02;
        tick();
        evt_vld = 0;
        chk("clr_busy_before", clear_busy, 0);
        clear_req = 1;
        tick();
        clear_req = 0;
        chk("clr_busy_after_req", clear_busy, 1);
        repeat (3) tick();
        act_done = 1;
        tick();
        act_done = 0;
        chk("clr_idle_cen", mem_cen, 0);
        chk("clr_idle_busy", clear_busy, 1);
        tick();
        for (int k = 0; k < 12; k++) begin
            chk("clr_cen", mem_cen, 1);
            chk("clr_rw", mem_rw, 1);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_x", mem_addr_x, 64'(xs[k]));
            chk("clr_y", mem_addr_y, 64'(ys[k]));
            chk("clr_busy", clear_busy, 1);
            chk("clr_no_issue", act_vld, 0);
            tick();
        end
        chk("clr_done_cen", mem_cen, 0);
        chk("clr_done_busy", clear_busy, 0);
        check_issue(19'h00F01, 16'h0F01);
        finish_busy(2);
        check_issue(19'h00F02, 16'h0F02);

        // Timeout on F2; G queued behind it
        tick();
        evt_vld = 1; evt_in = 19'h7ABCD; evt_ts = 16'hBEEF;
        act_cen = 1; act_addr_x = 9'h033;
        tick();
        evt_vld = 0;
        repeat (62) tick();
        chk("to_not_yet", timeout_err, 0);
        tick();
        chk("to_set", timeout_err, 1);
        chk("to_idle_vld", act_vld, 0);
        act_cen = 0;
        tick();
        chk("to_next_vld", act_vld, 1);
        chk("to_next_evt", act_cavier, 19'h7ABCD);
        finish_busy(2);
        repeat (5) tick();
        chk("to_sticky", timeout_err, 1);

        // Reset in the middle of a sweep, with an event queued
        evt_vld = 1; evt_in = 19'h01234; evt_ts = 16'h0042; clear_req = 1;
        tick();
        evt_vld = 0; clear_req = 0;
        tick();
        repeat (5) tick();
        chk("rc_write5_x", mem_addr_x, 1);
        chk("rc_write5_y", mem_addr_y, 1);
        chk("rc_write5_cen", mem_cen, 1);
        rst = 1;
        #1;
        chk("rc_cen", mem_cen, 0);
        chk("rc_rw", mem_rw, 0);
        chk("rc_x", mem_addr_x, 0);
        chk("rc_busy", clear_busy, 0);
        chk("rc_rdy", evt_rdy, 1);
        chk("rc_cavier", act_cavier, 0);
        chk("rc_ts", act_ts, 0);
        chk("rc_drop", evt_drop, 0);
        chk("rc_terr", timeout_err, 0);
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            chk("rc_post_cen", mem_cen, 0);
            chk("rc_post_vld", act_vld, 0);
            chk("rc_post_busy", clear_busy, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
